// File: rtl/fifo_line_pkg.sv
// Shared state encoding and sizing helper for the line FIFO scheduler.
package fifo_line_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } line_state_t;

    // Ceiling log2, also used by the FIFO to size its pointers.
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/line_skid_buf.sv
// Two-entry {last, data} skid buffer that absorbs the FIFO's registered read latency.
module line_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_last_o,
    output logic                  valid_o,
    output logic [1:0]            cnt_o
);

    logic [DATA_WIDTH-1:0] data0_q;
    logic [DATA_WIDTH-1:0] data1_q;
    logic                  last0_q;
    logic                  last1_q;
    logic [1:0]            cnt_q;
    logic                  pop;

    assign pop         = pop_i && (cnt_q != 2'd0);
    assign valid_o     = (cnt_q != 2'd0);
    assign head_data_o = data0_q;
    assign head_last_o = last0_q && (cnt_q != 2'd0);
    assign cnt_o       = cnt_q;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        data0_q <= push_data_i;
                        last0_q <= push_last_i;
                        cnt_q   <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        data1_q <= push_data_i;
                        last1_q <= push_last_i;
                        cnt_q   <= 2'd2;
                    end
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    cnt_q   <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        data0_q <= push_data_i;
                        last0_q <= push_last_i;
                    end else begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= push_data_i;
                        last1_q <= push_last_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_line_sched.sv
// Read/write sequencer for the single-clock line FIFO: valid/ready streams on both sides,
// line-at-a-time release with flush of partial lines.
module fifo_line_sched
    import fifo_line_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 640,
    parameter int LINE_LEN   = 640,
    localparam int LW        = clogb2(DATA_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic [LW-1:0]         level_o,
    output logic                  line_done_o
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DATA_DEPTH);
    localparam logic [LW-1:0] LINE_L  = LW'(LINE_LEN);

    line_state_t   state_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [LW-1:0] rd_left_q;
    logic          flush_pend_q;
    logic          inflight_q;
    logic          inflight_last_q;
    logic          line_done_q;
    logic [1:0]    skid_cnt;

    assign s_ready      = !rst && (level_q != DEPTH_L);
    assign fifo_wr_en   = s_valid && s_ready;
    assign fifo_wr_data = s_data;

    // Never let skid plus the in-flight read exceed the two skid slots.
    assign fifo_rd_en = !rst && (state_q != WAIT) && (level_q != '0) && (rd_left_q != '0)
                        && (({1'b0, skid_cnt} + {2'b00, inflight_q}) < 3'd2);

    assign level_o     = level_q;
    assign line_done_o = line_done_q;

    always_comb begin
        level_d = level_q;
        if (fifo_wr_en && !fifo_rd_en) begin
            level_d = level_q + 1'b1;
        end else if (!fifo_wr_en && fifo_rd_en) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT;
            rd_left_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (level_q >= LINE_L) begin
                        state_q      <= STREAM;
                        rd_left_q    <= LINE_L;
                        flush_pend_q <= flush_pend_q || flush_i;
                    end else if (flush_i || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                        if (level_q != '0) begin
                            state_q   <= FLUSH;
                            rd_left_q <= level_q;
                        end
                    end
                end
                STREAM, FLUSH: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (fifo_rd_en) begin
                        rd_left_q <= rd_left_q - 1'b1;
                        if (rd_left_q == LW'(1)) begin
                            state_q <= WAIT;
                        end
                    end
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            line_done_q     <= 1'b0;
        end else begin
            level_q         <= level_d;
            inflight_q      <= fifo_rd_en;
            inflight_last_q <= (rd_left_q == LW'(1));
            line_done_q     <= m_valid && m_ready && m_last;
        end
    end

    line_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i(fifo_rd_data),
        .push_last_i(inflight_last_q),
        .pop_i      (m_valid && m_ready),
        .head_data_o(m_data),
        .head_last_o(m_last),
        .valid_o    (m_valid),
        .cnt_o      (skid_cnt)
    );

    // The level counter must track the FIFO's own flags exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((level_q == DEPTH_L) == fifo_full);
            assert ((level_q == '0) == fifo_empty);
            assert (!(fifo_wr_en && fifo_full));
            assert (!(fifo_rd_en && fifo_empty));
        end
    end

endmodule
